// File: rtl/alu_pkg.sv
// Shared constants for the MIPS ALU datapath blocks.
// Operand width and the carry-lookahead block geometry used by the subtractor.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned CLA_BITS      = 4;

endpackage

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder slice.
// Exposes group propagate/generate so a second-level unit can compute block carries.
module cla_4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_p,
    output logic       o_g
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = w_p ^ w_c;

    assign o_p = &w_p;
    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/sub_32b.sv
// Registered subtractor with borrow-in: O = A - B - C_in, plus carry (no-borrow) and overflow.
// Built as A + ~B + ~C_in over 4-bit CLA slices joined by a second-level lookahead unit.
module sub_32b
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] O,
    output logic             V,
    output logic             C_out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in
);

    localparam int unsigned NUM_BLK = WIDTH / CLA_BITS;

    logic [WIDTH-1:0]   w_b_n;
    logic               w_cin_n;
    logic [WIDTH-1:0]   w_diff;
    logic [NUM_BLK-1:0] w_blk_p;
    logic [NUM_BLK-1:0] w_blk_g;
    logic [NUM_BLK:0]   w_blk_c;
    logic               w_term;
    logic               w_prop;
    logic               w_v_next;

    logic [WIDTH-1:0]   r_o;
    logic               r_v;
    logic               r_c_out;

    assign w_b_n   = ~B;
    assign w_cin_n = ~C_in;

    for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_cla
        cla_4b u_cla (
            .i_a   (A[CLA_BITS*gi +: CLA_BITS]),
            .i_b   (w_b_n[CLA_BITS*gi +: CLA_BITS]),
            .i_cin (w_blk_c[gi]),
            .o_sum (w_diff[CLA_BITS*gi +: CLA_BITS]),
            .o_p   (w_blk_p[gi]),
            .o_g   (w_blk_g[gi])
        );
    end

    // Each block carry is a flat sum-of-products over lower block P/G, not a ripple chain.
    always_comb begin
        w_blk_c    = '0;
        w_blk_c[0] = w_cin_n;
        w_term     = 1'b0;
        w_prop     = 1'b0;
        for (int i = 0; i < NUM_BLK; i++) begin
            w_term = w_blk_g[i];
            w_prop = w_blk_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prop & w_blk_g[j]);
                w_prop = w_prop & w_blk_p[j];
            end
            w_blk_c[i+1] = w_term | (w_prop & w_cin_n);
        end
    end

    assign w_v_next = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o     <= '0;
            r_v     <= 1'b0;
            r_c_out <= 1'b0;
        end else begin
            r_o     <= w_diff;
            r_v     <= w_v_next;
            r_c_out <= w_blk_c[NUM_BLK];
        end
    end

    assign O     = r_o;
    assign V     = r_v;
    assign C_out = r_c_out;

endmodule

// File: tb/tb_sub_32b.sv
// Self-checking bench for sub_32b: directed cases, mid-cycle reset, and random vectors
// compared against an arithmetic reference model with one cycle of latency.
module tb_sub_32b;

    logic        clk;
    logic        rst_n;
    logic [31:0] O;
    logic        V;
    logic        C_out;
    logic [31:0] A;
    logic [31:0] B;
    logic        C_in;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] o;
        logic        c;
        logic        v;
    } vec_t;

    vec_t dirs [12];

    sub_32b #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .O     (O),
        .V     (V),
        .C_out (C_out),
        .A     (A),
        .B     (B),
        .C_in  (C_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference from plain integer arithmetic: unsigned compare for carry, true signed
    // range test for overflow.
    task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             output logic [31:0] o, output logic c, output logic v);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint lc;
        longint ud;
        longint sd;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lc = longint'({63'b0, cin});
        ud = ua - ub - lc;
        sd = sa - sb - lc;
        o  = ud[31:0];
        c  = (ua >= ub + lc);
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
        @(negedge clk);
        A    = a;
        B    = b;
        C_in = cin;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_o;
    logic        exp_c;
    logic        exp_v;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'hFFFF_FFFF;
        specials[5] = 32'h8000_0001;
        if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        dirs[0]  = '{32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        dirs[1]  = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        dirs[2]  = '{32'h0002_0001, 32'h0080_0001, 1'b0, 32'hFF82_0000, 1'b0, 1'b0};
        dirs[3]  = '{32'h8000_0001, 32'h8000_0002, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        dirs[4]  = '{32'h0000_0002, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        dirs[5]  = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        dirs[6]  = '{32'h8040_0001, 32'h0000_0001, 1'b1, 32'h803F_FFFF, 1'b1, 1'b0};
        dirs[7]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        dirs[8]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        dirs[9]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        dirs[10] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        dirs[11] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h1234_5678;
        C_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_O", O, 32'h0);
        check("reset_V", {31'b0, V}, 32'h0);
        check("reset_C", {31'b0, C_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dirs[k]) begin
            drive(dirs[k].a, dirs[k].b, dirs[k].cin);
            check($sformatf("dir%0d_O", k), O, dirs[k].o);
            check($sformatf("dir%0d_C", k), {31'b0, C_out}, {31'b0, dirs[k].c});
            check($sformatf("dir%0d_V", k), {31'b0, V}, {31'b0, dirs[k].v});
        end

        // Mid-cycle reset: outputs clear before the next edge and stay clear while held.
        @(negedge clk);
        A    = 32'd5;
        B    = 32'd3;
        C_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_O", O, 32'h0);
        check("midrst_V", {31'b0, V}, 32'h0);
        check("midrst_C", {31'b0, C_out}, 32'h0);
        @(posedge clk);
        #1;
        check("heldrst_O", O, 32'h0);
        check("heldrst_C", {31'b0, C_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_O", O, 32'd2);
        check("postrst_C", {31'b0, C_out}, 32'd1);
        check("postrst_V", {31'b0, V}, 32'd0);

        for (int n = 0; n < 10000; n++) begin
            ra = pick_operand();
            rb = ($urandom_range(0, 15) == 0) ? ra : pick_operand();
            rc = 1'($urandom_range(0, 1));
            ref_model(ra, rb, rc, exp_o, exp_c, exp_v);
            drive(ra, rb, rc);
            check($sformatf("rnd%0d_O a=%h b=%h ci=%0b", n, ra, rb, rc), O, exp_o);
            check($sformatf("rnd%0d_C", n), {31'b0, C_out}, {31'b0, exp_c});
            check($sformatf("rnd%0d_V", n), {31'b0, V}, {31'b0, exp_v});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
